// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared constants for the I2C target register file.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - register-file geometry (REG_AW address bits, REG_DW data bits)
//   - maj3(): 2-of-3 vote used by the optional line glitch filter
package i2c_target_pkg;

  localparam int REG_AW = 4;
  localparam int REG_DW = 8;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] WR_BYTE  = 3'd3;
  localparam logic [2:0] WR_ACK   = 3'd4;
  localparam logic [2:0] RD_BYTE  = 3'd5;
  localparam logic [2:0] RD_ACK   = 3'd6;
  localparam logic [2:0] IGNORE   = 3'd7;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: conditions one I2C pad line (SCL or SDA).
//   2-flop synchroniser, optional 3-sample majority filter, edge detect.
//   Build option: I2C_TARGET_GLITCH_FILTER_EN adds the majority filter
//   (rejects pulses of 1 clk or shorter, pad-to-event latency 5 clk
//   instead of 3).
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-low reset
//   pad_i    raw pad input
//   level_o  conditioned line level
//   rise_o   one-clk pulse on a conditioned rising edge
//   fall_o   one-clk pulse on a conditioned falling edge
module i2c_line_cond (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Flops reset to 1 (idle bus level) so leaving reset makes no edge.
  logic [1:0] sync_q;
  logic       line_s;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], pad_i};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] filt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) filt_q <= 3'b111;
    else        filt_q <= {filt_q[1:0], sync_q[1]};
  end

  assign line_s = i2c_target_pkg::maj3(filt_q);
`else
  assign line_s = sync_q[1];
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) prev_q <= 1'b1;
    else        prev_q <= line_s;
  end

  assign level_o = line_s;
  assign rise_o  = line_s & ~prev_q;
  assign fall_o  = ~line_s & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing a 16x8 register file.
//   Write: START, addr+W, pointer byte, data bytes (auto-increment).
//   Read : START, addr+R, data bytes from pointer (auto-increment).
//   Build option: I2C_TARGET_GLITCH_FILTER_EN (see i2c_line_cond).
// Ports:
//   clk_i, rst_i          system clock, async active-low reset
//   scl_pad_i, sda_pad_i  bus pad inputs
//   sda_pad_o             always 0 (open drain)
//   sda_pad_oen_o         0 pulls SDA low
//   fab_we_i/adr_i/dat_i  fabric write port (wins same-address collisions)
//   fab_dat_o             reg[fab_adr_i], combinational
//   wr_stb_o/adr_o/dat_o  one-clk strobe for each I2C data write
//   busy_o                high from START to STOP
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in address + R/W
// ADDR_ACK | driving address ACK
// WR_BYTE  | shifting in pointer/data byte
// WR_ACK   | driving data ACK
// RD_BYTE  | driving read data MSB first
// RD_ACK   | sampling master ACK/NACK
// IGNORE   | not addressed / NACKed, wait for START or STOP
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]        I2C_ADDR = 7'h48,
  parameter logic [REG_DW-1:0] RST_VAL  = 8'h00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_pad_oen_o,
  input  logic              fab_we_i,
  input  logic [REG_AW-1:0] fab_adr_i,
  input  logic [REG_DW-1:0] fab_dat_i,
  output logic [REG_DW-1:0] fab_dat_o,
  output logic              wr_stb_o,
  output logic [REG_AW-1:0] wr_adr_o,
  output logic [REG_DW-1:0] wr_dat_o,
  output logic              busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond u_scl (.clk_i(clk_i), .rst_i(rst_i), .pad_i(scl_pad_i),
                       .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_line_cond u_sda (.clk_i(clk_i), .rst_i(rst_i), .pad_i(sda_pad_i),
                       .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  logic [REG_DW-1:0] regs_q [2**REG_AW];
  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  // 7 bits suffice: the 8th received bit comes straight from sda_lvl, and
  // on reads the MSB goes straight to the pad at load time.
  logic [6:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              first_q, first_d;
  logic              rw_q, rw_d;
  logic              oen_q, oen_d;
  logic              busy_q, busy_d;
  logic              stb_q, stb_d;
  logic [REG_AW-1:0] wadr_q, wadr_d;
  logic [REG_DW-1:0] wdat_q, wdat_d;
  logic              i2c_we, load;
  logic [REG_DW-1:0] rx_byte, rd_data;
  logic              start_det, stop_det;

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign rx_byte   = {shift_q, sda_lvl};
  assign rd_data   = regs_q[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    rw_d    = rw_q;
    oen_d   = oen_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
    i2c_we  = 1'b0;
    load    = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      busy_d  = 1'b1;
      oen_d   = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oen_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (rx_byte[7:1] == I2C_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = rx_byte[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // ACK states: first SCL fall pulls SDA low, second one ends the ACK.
        ADDR_ACK: if (scl_fall) begin
          if (oen_q) begin
            oen_d = 1'b0;
          end else begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d = RD_BYTE;
              load    = 1'b1;
            end else begin
              state_d = WR_BYTE;
              first_d = 1'b1;
              oen_d   = 1'b1;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d = WR_ACK;
            if (first_q) begin
              ptr_d   = rx_byte[3:0];
              first_d = 1'b0;
            end else begin
              i2c_we = 1'b1;
              stb_d  = 1'b1;
              wadr_d = ptr_q;
              wdat_d = rx_byte;
              ptr_d  = ptr_q + 4'd1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (oen_q) begin
            oen_d = 1'b0;
          end else begin
            oen_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = WR_BYTE;
          end
        end
        // cnt counts master sample edges; cnt==0 on a fall means a fresh
        // byte is due after the master's ACK.
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              load = 1'b1;
            end else if (cnt_q == 4'd8) begin
              oen_d   = 1'b1;
              state_d = RD_ACK;
            end else begin
              oen_d   = shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_lvl) begin
            state_d = RD_BYTE;
            cnt_d   = 4'd0;
          end else begin
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end
    if (load) begin
      shift_d = rd_data[6:0];
      oen_d   = rd_data[7];
      ptr_d   = ptr_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 7'd0;
      ptr_q   <= '0;
      first_q <= 1'b0;
      rw_q    <= 1'b0;
      oen_q   <= 1'b1;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      rw_q    <= rw_d;
      oen_q   <= oen_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
    end
  end

  // Fabric write is issued last so it wins a same-address collision.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2**REG_AW; i++) regs_q[i] <= RST_VAL;
    end else begin
      if (i2c_we)   regs_q[ptr_q]     <= rx_byte;
      if (fab_we_i) regs_q[fab_adr_i] <= fab_dat_i;
    end
  end

  assign sda_pad_o     = 1'b0;
  assign sda_pad_oen_o = oen_q;
  assign fab_dat_o     = regs_q[fab_adr_i];
  assign wr_stb_o      = stb_q;
  assign wr_adr_o      = wadr_q;
  assign wr_dat_o      = wdat_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
module tb_i2c_target_regfile;

  localparam int Q = 10;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int LAT = 5;
  localparam logic GLITCH_EXP = 1'b0;
`else
  localparam int LAT = 3;
  localparam logic GLITCH_EXP = 1'b1;
`endif

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WR    = 3'd1;
  localparam logic [2:0] OP_WRC   = 3'd2;
  localparam logic [2:0] OP_RDA   = 3'd3;
  localparam logic [2:0] OP_RDN   = 3'd4;
  localparam logic [2:0] OP_STOP  = 3'd5;

  typedef struct {
    logic [2:0] op;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       scl_m, sda_m, sda_bus;
  logic       sda_pad_o, sda_pad_oen_o;
  logic       fab_we_i;
  logic [3:0] fab_adr_i;
  logic [7:0] fab_dat_i, fab_dat_o;
  logic       wr_stb_o, busy_o;
  logic [3:0] wr_adr_o;
  logic [7:0] wr_dat_o;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  logic [3:0] stb_adr [8];
  logic [7:0] stb_dat [8];
  vec_t tv[$];

  assign sda_bus = sda_m & (sda_pad_oen_o | sda_pad_o);

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .clk_i(clk), .rst_i(rst_i),
    .scl_pad_i(scl_m), .sda_pad_i(sda_bus),
    .sda_pad_o(sda_pad_o), .sda_pad_oen_o(sda_pad_oen_o),
    .fab_we_i(fab_we_i), .fab_adr_i(fab_adr_i), .fab_dat_i(fab_dat_i),
    .fab_dat_o(fab_dat_o),
    .wr_stb_o(wr_stb_o), .wr_adr_o(wr_adr_o), .wr_dat_o(wr_dat_o),
    .busy_o(busy_o)
  );

  always @(negedge clk) begin
    if (wr_stb_o === 1'b1) begin
      if (stb_cnt < 8) begin
        stb_adr[stb_cnt] = wr_adr_o;
        stb_dat[stb_cnt] = wr_dat_o;
      end
      stb_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(input logic [2:0] op, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.op = op; v.dat = d; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic rd_fab(input logic [3:0] a, output logic [7:0] d);
    fab_adr_i = a;
    #1;
    d = fab_dat_o;
  endtask

  task automatic fab_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    fab_we_i = 1'b1; fab_adr_i = a; fab_dat_i = d;
    @(negedge clk);
    fab_we_i = 1'b0;
  endtask

  // coll: fabric writes 0x33 to reg 5 on the very clk the I2C write lands.
  task automatic send_bit(input logic b, input bit coll);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl_m = 1'b1;
    if (coll) begin
      wait_clk(LAT - 1);
      fab_we_i = 1'b1; fab_adr_i = 4'd5; fab_dat_i = 8'h33;
      wait_clk(1);
      fab_we_i = 1'b0;
      wait_clk(2*Q - LAT);
    end else begin
      wait_clk(2*Q);
    end
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit coll, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], coll && (i == 0));
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q); ack = (sda_bus == 1'b0);
    wait_clk(Q); scl_m = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); sda_m = 1'b1;
      wait_clk(Q); scl_m = 1'b1;
      wait_clk(Q); d[i] = sda_bus;
      wait_clk(Q); scl_m = 1'b0;
    end
    send_bit(nack, 1'b0);
  endtask

  task automatic apply(input int lo, input int hi);
    logic       ack;
    logic [7:0] d;
    for (int i = lo; i < hi; i++) begin
      case (tv[i].op)
        OP_START: begin
          i2c_start();
          check($sformatf("vec%0d_busy", i), busy_o, 1'b1);
        end
        OP_WR, OP_WRC: begin
          write_byte(tv[i].dat, tv[i].op == OP_WRC, ack);
          check($sformatf("vec%0d_ack", i), ack, tv[i].exp[0]);
        end
        OP_RDA, OP_RDN: begin
          read_byte(tv[i].op == OP_RDN, d);
          check($sformatf("vec%0d_rdata", i), d, tv[i].exp);
          if (tv[i].op == OP_RDN)
            check($sformatf("vec%0d_release", i), sda_pad_oen_o, 1'b1);
        end
        default: begin
          i2c_stop();
          check($sformatf("vec%0d_idle", i), busy_o, 1'b0);
        end
      endcase
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       ack, seen;
    int s1, s2, s3, s4, s5;

    // write with auto-increment
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h90, 8'h01); add(OP_WR, 8'h03, 8'h01);
    add(OP_WR, 8'hA5, 8'h01); add(OP_WR, 8'h5A, 8'h01); add(OP_STOP, 8'h00, 8'h00);
    s1 = tv.size();
    // pointer 15, repeated START, read with wrap
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h90, 8'h01); add(OP_WR, 8'h0F, 8'h01);
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h91, 8'h01);
    add(OP_RDA, 8'h00, 8'h11); add(OP_RDN, 8'h00, 8'h22); add(OP_STOP, 8'h00, 8'h00);
    s2 = tv.size();
    // address mismatch
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h92, 8'h00); add(OP_WR, 8'hFF, 8'h00);
    add(OP_STOP, 8'h00, 8'h00);
    s3 = tv.size();
    // fabric collision on reg 5
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h90, 8'h01); add(OP_WR, 8'h05, 8'h01);
    add(OP_WRC, 8'h77, 8'h01); add(OP_STOP, 8'h00, 8'h00);
    s4 = tv.size();
    // full write after a mid-transfer reset
    add(OP_START, 8'h00, 8'h00); add(OP_WR, 8'h90, 8'h01); add(OP_WR, 8'h07, 8'h01);
    add(OP_WR, 8'hC3, 8'h01); add(OP_STOP, 8'h00, 8'h00);
    s5 = tv.size();

    scl_m = 1'b1; sda_m = 1'b1;
    fab_we_i = 1'b0; fab_adr_i = 4'd0; fab_dat_i = 8'h00;
    rst_i = 1'b0;
    wait_clk(3);
    check("rst_oen", sda_pad_oen_o, 1'b1);
    check("rst_sda_o", sda_pad_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_stb", wr_stb_o, 1'b0);
    check("rst_wadr", wr_adr_o, 4'h0);
    check("rst_wdat", wr_dat_o, 8'h00);
    rd_fab(4'd9, d); check("rst_reg9", d, 8'h00);
    rst_i = 1'b1;
    wait_clk(5);

    apply(0, s1);
    rd_fab(4'd3, d); check("t1_reg3", d, 8'hA5);
    rd_fab(4'd4, d); check("t1_reg4", d, 8'h5A);
    check("t1_stb_cnt", stb_cnt, 2);
    check("t1_stb0_adr", stb_adr[0], 4'd3);
    check("t1_stb0_dat", stb_dat[0], 8'hA5);
    check("t1_stb1_adr", stb_adr[1], 4'd4);
    check("t1_stb1_dat", stb_dat[1], 8'h5A);

    fab_write(4'd15, 8'h11);
    fab_write(4'd0, 8'h22);
    rd_fab(4'd15, d); check("fab_reg15", d, 8'h11);
    apply(s1, s2);
    check("t2_stb_cnt", stb_cnt, 2);

    apply(s2, s3);
    check("t3_stb_cnt", stb_cnt, 2);
    rd_fab(4'd3, d); check("t3_reg3", d, 8'hA5);
    rd_fab(4'd15, d); check("t3_reg15", d, 8'h11);
    rd_fab(4'd0, d); check("t3_reg0", d, 8'h22);

    apply(s3, s4);
    rd_fab(4'd5, d); check("coll_reg5", d, 8'h33);
    check("coll_stb_cnt", stb_cnt, 3);
    check("coll_stb_adr", stb_adr[2], 4'd5);
    check("coll_stb_dat", stb_dat[2], 8'h77);

    // reset during bit 4 of the first data byte (0x0A)
    i2c_start();
    write_byte(8'h90, 1'b0, ack);
    check("rst_seq_ack", ack, 1'b1);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl_m = 1'b1;
    wait_clk(Q);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_oen", sda_pad_oen_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    for (int a = 0; a < 16; a++) begin
      rd_fab(a[3:0], d);
      check($sformatf("midrst_reg%0d", a), d, 8'h00);
    end
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(3);
    rst_i = 1'b1;
    wait_clk(5);
    apply(s4, s5);
    rd_fab(4'd7, d); check("post_rst_reg7", d, 8'hC3);
    check("post_rst_stb_cnt", stb_cnt, 4);
    check("post_rst_stb_dat", stb_dat[3], 8'hC3);

    // 1-clk SDA low glitch while SCL high in IDLE
    wait_clk(5);
    seen = 1'b0;
    sda_m = 1'b0;
    wait_clk(1);
    sda_m = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy_o === 1'b1) seen = 1'b1;
    end
    check("glitch_busy_seen", seen, GLITCH_EXP);
    check("glitch_busy_end", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
